// File: rtl/bt_time_cmd_ctrl.sv
// Parses "T"+HHMMSS and "A"+HHMM ASCII frames from the UART receiver into range-checked
// binary load strobes for the clock and alarm counters.
module bt_time_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       busy,
   output logic       time_load,
   output logic [4:0] time_hour,
   output logic [5:0] time_min,
   output logic [5:0] time_sec,
   output logic       alarm_load,
   output logic [4:0] alarm_hour,
   output logic [5:0] alarm_min,
   output logic       cmd_err,
   output logic [1:0] err_code
);

   localparam int CntW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StCollect, StCommit} state_e;

   state_e          state_q, state_d;
   logic            kind_q, kind_d;  // 0: time frame, 1: alarm frame
   logic [2:0]      idx_q, idx_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      digits_q [6];
   logic [3:0]      digits_d [6];

   logic       time_load_d, alarm_load_d, cmd_err_d;
   logic [4:0] time_hour_d, alarm_hour_d;
   logic [5:0] time_min_d, time_sec_d, alarm_min_d;
   logic [1:0] err_code_d;

   logic       is_digit, is_time_cmd, is_alarm_cmd, range_ok;
   logic [2:0] need;
   logic [6:0] hour_val, min_val, sec_val;

   function automatic logic [6:0] times10(input logic [3:0] d);
      return ({3'b000, d} << 3) + ({3'b000, d} << 1);
   endfunction

   assign is_digit     = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_time_cmd  = (rx_data == 8'h54) || (rx_data == 8'h74);
   assign is_alarm_cmd = (rx_data == 8'h41) || (rx_data == 8'h61);
   assign need         = kind_q ? 3'd4 : 3'd6;

   assign hour_val = times10(digits_q[0]) + {3'b000, digits_q[1]};
   assign min_val  = times10(digits_q[2]) + {3'b000, digits_q[3]};
   assign sec_val  = times10(digits_q[4]) + {3'b000, digits_q[5]};
   assign range_ok = (hour_val <= 7'd23) && (digits_q[2] <= 4'd5) &&
                     (kind_q || (digits_q[4] <= 4'd5));

   assign busy = (state_q == StCollect);

   always_comb begin
      state_d      = state_q;
      kind_d       = kind_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      digits_d     = digits_q;
      time_load_d  = 1'b0;
      alarm_load_d = 1'b0;
      cmd_err_d    = 1'b0;
      err_code_d   = err_code;
      time_hour_d  = time_hour;
      time_min_d   = time_min;
      time_sec_d   = time_sec;
      alarm_hour_d = alarm_hour;
      alarm_min_d  = alarm_min;

      unique case (state_q)
         StIdle: begin
            if (rx_valid && (is_time_cmd || is_alarm_cmd)) begin
               kind_d     = is_alarm_cmd;
               idx_d      = 3'd0;
               cnt_d      = '0;
               err_code_d = 2'd0;
               state_d    = StCollect;
            end
         end
         StCollect: begin
            // An arriving byte takes priority over a same-cycle timeout expiry.
            if (rx_valid) begin
               cnt_d = '0;
               if (is_digit) begin
                  digits_d[idx_q] = rx_data[3:0];
                  idx_d           = idx_q + 3'd1;
                  if (idx_q == need - 3'd1) state_d = StCommit;
               end else begin
                  cmd_err_d  = 1'b1;
                  err_code_d = 2'd1;
                  state_d    = StIdle;
               end
            end else if (cnt_q == CntLast) begin
               cmd_err_d  = 1'b1;
               err_code_d = 2'd3;
               state_d    = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCommit: begin
            if (!range_ok) begin
               cmd_err_d  = 1'b1;
               err_code_d = 2'd2;
            end else if (kind_q) begin
               alarm_load_d = 1'b1;
               alarm_hour_d = hour_val[4:0];
               alarm_min_d  = min_val[5:0];
            end else begin
               time_load_d = 1'b1;
               time_hour_d = hour_val[4:0];
               time_min_d  = min_val[5:0];
               time_sec_d  = sec_val[5:0];
            end
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         kind_q     <= 1'b0;
         idx_q      <= 3'd0;
         cnt_q      <= '0;
         digits_q   <= '{default: 4'd0};
         time_load  <= 1'b0;
         alarm_load <= 1'b0;
         cmd_err    <= 1'b0;
         err_code   <= 2'd0;
         time_hour  <= 5'd0;
         time_min   <= 6'd0;
         time_sec   <= 6'd0;
         alarm_hour <= 5'd0;
         alarm_min  <= 6'd0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         digits_q   <= digits_d;
         time_load  <= time_load_d;
         alarm_load <= alarm_load_d;
         cmd_err    <= cmd_err_d;
         err_code   <= err_code_d;
         time_hour  <= time_hour_d;
         time_min   <= time_min_d;
         time_sec   <= time_sec_d;
         alarm_hour <= alarm_hour_d;
         alarm_min  <= alarm_min_d;
      end
   end

endmodule

// File: tb/tb_bt_time_cmd_ctrl.sv
// Directed bench for bt_time_cmd_ctrl: a scoreboard queue of expected strobes and output
// snapshots, popped by a monitor whenever the DUT raises a strobe.
module tb_bt_time_cmd_ctrl;

   localparam int unsigned To = 100;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       busy, time_load, alarm_load, cmd_err;
   logic [4:0] time_hour, alarm_hour;
   logic [5:0] time_min, time_sec, alarm_min;
   logic [1:0] err_code;

   always #5 clk = ~clk;

   bt_time_cmd_ctrl #(.TIMEOUT_CYCLES(To)) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .time_load  (time_load),
      .time_hour  (time_hour),
      .time_min   (time_min),
      .time_sec   (time_sec),
      .alarm_load (alarm_load),
      .alarm_hour (alarm_hour),
      .alarm_min  (alarm_min),
      .cmd_err    (cmd_err),
      .err_code   (err_code)
   );

   typedef struct packed {
      logic [1:0]  typ;   // 0 time_load, 1 alarm_load, 2 cmd_err
      logic [29:0] outs;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model of the registered outputs
   logic [4:0] m_th = '0, m_ah = '0;
   logic [5:0] m_tm = '0, m_ts = '0, m_am = '0;
   logic [1:0] m_code = '0;

   logic [29:0] outs_now;
   assign outs_now = {time_hour, time_min, time_sec, alarm_hour, alarm_min, err_code};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] snap();
      return {m_th, m_tm, m_ts, m_ah, m_am, m_code};
   endfunction

   function automatic logic strobe_of(input logic [1:0] typ);
      return (typ == 2'd0) ? time_load : (typ == 2'd1) ? alarm_load : cmd_err;
   endfunction

   task automatic push(input logic [1:0] typ);
      exp_t e;
      e.typ  = typ;
      e.outs = snap();
      sb.push_back(e);
   endtask

   // Called at a negedge; the byte is sampled on the following posedge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   // Sends a whole frame, queues its expected result before the last byte, then checks
   // the two-cycle strobe latency and single-cycle width.
   task automatic frame(input string s, input logic [1:0] typ, input string tag);
      send_str(s.substr(0, s.len() - 2));
      push(typ);
      send_byte(s[s.len() - 1]);
      check({tag, "_n1"}, 64'(strobe_of(typ)), 64'd0);
      @(negedge clk);
      check({tag, "_strobe"}, 64'(strobe_of(typ)), 64'd1);
      check({tag, "_outs"}, 64'(outs_now), 64'(snap()));
      @(negedge clk);
      check({tag, "_one_cycle"}, 64'(strobe_of(typ)), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   exp_t       mon_e;
   logic [1:0] mon_t;
   always @(negedge clk) begin
      if (!rst && (time_load || alarm_load || cmd_err)) begin
         mon_t = time_load ? 2'd0 : (alarm_load ? 2'd1 : 2'd2);
         check("strobe_onehot", 64'(int'(time_load) + int'(alarm_load) + int'(cmd_err)), 64'd1);
         check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("sb_type", 64'(mon_t), 64'(mon_e.typ));
            check("sb_outs", 64'(outs_now), 64'(mon_e.outs));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_outs", 64'(outs_now), 64'd0);
      check("rst_strobes", 64'({busy, time_load, alarm_load, cmd_err}), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Time set
      send_str("T");
      check("busy_after_T", 64'(busy), 64'd1);
      m_th = 5'd12; m_tm = 6'd34; m_ts = 6'd56; m_code = 2'd0;
      frame("123456", 2'd0, "time1");

      // Alarm set, lowercase; time outputs must stay put
      m_ah = 5'd7; m_am = 6'd30;
      frame("a0730", 2'd1, "alarm1");

      // Range errors
      m_code = 2'd2;
      frame("T240000", 2'd2, "range_hour");
      frame("T236000", 2'd2, "range_min");

      // Bad character
      send_str("T1");
      m_code = 2'd1;
      push(2'd2);
      send_byte("x");
      check("badchar_err", 64'(cmd_err), 64'd1);
      check("badchar_code", 64'(err_code), 64'd1);
      check("badchar_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("badchar_one_cycle", 64'(cmd_err), 64'd0);
      send_byte(8'h0d);
      send_byte(8'h0a);
      repeat (3) @(negedge clk);
      check("crlf_no_err", 64'({cmd_err, err_code}), 64'({1'b0, 2'd1}));
      m_th = 5'd9; m_tm = 6'd59; m_ts = 6'd7; m_code = 2'd0;
      frame("T095907", 2'd0, "time2");

      // Timeout after silence
      send_str("A1");
      m_code = 2'd3;
      push(2'd2);
      got = 0;
      for (int j = 1; j <= 150; j++) begin
         @(negedge clk);
         if (cmd_err) begin
            got = j;
            break;
         end
      end
      check("timeout_latency", 64'(got), 64'd100);
      check("timeout_code", 64'(err_code), 64'd3);
      repeat (2) @(negedge clk);

      // Byte landing on the expiry cycle wins
      send_str("A1");
      m_ah = 5'd12; m_am = 6'd30; m_code = 2'd0;
      repeat (99) @(negedge clk);
      send_byte("2");
      check("expiry_no_err", 64'(cmd_err), 64'd0);
      check("expiry_busy", 64'(busy), 64'd1);
      frame("30", 2'd1, "alarm_expiry");

      // Reset mid-frame
      send_str("T12");
      rst = 1'b1;
      @(negedge clk);
      check("midrst_outs", 64'(outs_now), 64'd0);
      check("midrst_strobes", 64'({busy, time_load, alarm_load, cmd_err}), 64'd0);
      rst = 1'b0;
      m_th = '0; m_tm = '0; m_ts = '0; m_ah = '0; m_am = '0; m_code = '0;
      @(negedge clk);
      m_th = 5'd12; m_tm = 6'd34; m_ts = 6'd56;
      frame("T123456", 2'd0, "time3");

      repeat (4) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
